// File: rtl/spi_master.sv
// Read-only SPI master for an 8-bit ADC-style slave. Each frame is 16 sclk
// cycles (CPOL=1, sample on rise); the data byte sits in rises 4..11.
module spi_master #(
  parameter int HALF_DIV = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sdata,
  input  logic       start,
  output logic       sclk,
  output logic       cs_n,
  output logic [7:0] dout
);

  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(HALF_DIV - 1);
  // QUIET runs 2*HALF_DIV-1 cycles so the following IDLE cycle completes
  // 2*HALF_DIV cycles of cs_n high before the next frame can begin.
  localparam logic [DIV_W-1:0] QUIET_LAST = DIV_W'((HALF_DIV >= 2) ? HALF_DIV - 2 : 0);
  localparam logic [5:0]       TOG_LAST   = 6'd32;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    HOLD,
    QUIET
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [5:0]       tog;
  logic [15:0]      shreg;
  logic             q_ph;
  logic             div_end;
  logic             quiet_end;

  assign div_end   = (div == DIV_LAST);
  assign quiet_end = (HALF_DIV == 1) ? 1'b1 : (q_ph && (div == QUIET_LAST));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      div   <= '0;
      tog   <= '0;
      shreg <= '0;
      q_ph  <= 1'b0;
      sclk  <= 1'b1;
      cs_n  <= 1'b1;
      dout  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          cs_n <= 1'b1;
          sclk <= 1'b1;
          div  <= '0;
          tog  <= '0;
          q_ph <= 1'b0;
          if (start) begin
            cs_n  <= 1'b0;
            state <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (div_end) begin
            div   <= '0;
            sclk  <= 1'b0;
            tog   <= 6'd1;
            state <= SHIFT;
          end else begin
            div <= div + 1'b1;
          end
        end
        SHIFT: begin
          if (div_end) begin
            div  <= '0;
            sclk <= ~sclk;
            tog  <= tog + 1'b1;
            // sclk currently low means this edge is a rise: take the sample
            if (!sclk) shreg <= {shreg[14:0], sdata};
            if (tog == TOG_LAST - 6'd1) state <= HOLD;
          end else begin
            div <= div + 1'b1;
          end
        end
        HOLD: begin
          if (div_end) begin
            div   <= '0;
            q_ph  <= 1'b0;
            cs_n  <= 1'b1;
            dout  <= shreg[12:5];
            state <= QUIET;
          end else begin
            div <= div + 1'b1;
          end
        end
        QUIET: begin
          if (quiet_end) begin
            state <= IDLE;
          end else if (div_end) begin
            div  <= '0;
            q_ph <= 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: HALF_DIV=4 and HALF_DIV=1 instances, each with a
// behavioural slave, an edge/cycle monitor and a byte scoreboard.
module tb_spi_master;

  localparam int H0 = 4;
  localparam int H1 = 1;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start4 = 1'b0, start1 = 1'b0;
  logic sdata4 = 1'b0, sdata1 = 1'b0;
  logic sclk4, sclk1, cs_n4, cs_n1;
  logic [7:0] dout4, dout1;

  always #5 clk = ~clk;

  spi_master #(.HALF_DIV(H0)) dut4 (
    .clk(clk), .n_rst(n_rst), .sdata(sdata4), .start(start4),
    .sclk(sclk4), .cs_n(cs_n4), .dout(dout4)
  );

  spi_master #(.HALF_DIV(H1)) dut1 (
    .clk(clk), .n_rst(n_rst), .sdata(sdata1), .start(start1),
    .sclk(sclk1), .cs_n(cs_n1), .dout(dout1)
  );

  int checks = 0;
  int fails  = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // slave models: next bit presented after every sclk fall while selected
  logic [15:0] pat0 = '0, pat1 = '0;
  logic        post0 = 1'b1, post1 = 1'b1;
  int          fidx0 = 0, fidx1 = 0;

  always @(negedge cs_n4) fidx0 = 0;
  always @(negedge cs_n1) fidx1 = 0;
  always @(posedge cs_n4) sdata4 = post0;
  always @(posedge cs_n1) sdata1 = post1;
  always @(negedge sclk4) if (!cs_n4 && fidx0 < 16) begin sdata4 = pat0[15-fidx0]; fidx0++; end
  always @(negedge sclk1) if (!cs_n1 && fidx1 < 16) begin sdata1 = pat1[15-fidx1]; fidx1++; end

  // monitor, sampled on the falling clk edge
  logic [1:0] cs_v, sclk_v, prev_cs = 2'b11, prev_sclk = 2'b11;
  logic [7:0] dout_v [2];
  logic [7:0] prev_dout [2];
  assign cs_v   = {cs_n1, cs_n4};
  assign sclk_v = {sclk1, sclk4};
  assign dout_v[0] = dout4;
  assign dout_v[1] = dout1;

  int cyc = 0;
  int hd[2] = '{H0, H1};
  int starts[2] = '{0, 0}, done_cnt[2] = '{0, 0};
  int lowcnt[2] = '{0, 0}, frame_len[2] = '{0, 0};
  int falls[2] = '{0, 0}, rises[2] = '{0, 0};
  int hicnt[2] = '{0, 0}, hi_len[2] = '{0, 0};
  int last_fall[2] = '{0, 0}, spacing[2] = '{0, 0};
  int last_sf[2] = '{0, 0}, per_err[2] = '{0, 0}, dbad[2] = '{0, 0};

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (prev_cs[i] && !cs_v[i]) begin
        starts[i]++;
        spacing[i] = cyc - last_fall[i];
        last_fall[i] = cyc;
        hi_len[i] = hicnt[i];
        lowcnt[i] = 0; falls[i] = 0; rises[i] = 0; per_err[i] = 0; dbad[i] = 0;
      end
      if (!prev_cs[i] && cs_v[i]) begin
        done_cnt[i]++;
        frame_len[i] = lowcnt[i];
        hicnt[i] = 0;
      end
      if (cs_v[i]) hicnt[i]++;
      if (!cs_v[i]) begin
        lowcnt[i]++;
        if (prev_sclk[i] && !sclk_v[i]) begin
          if (falls[i] > 0 && cyc - last_sf[i] != 2 * hd[i]) per_err[i]++;
          last_sf[i] = cyc;
          falls[i]++;
        end
        if (!prev_sclk[i] && sclk_v[i]) rises[i]++;
        if (dout_v[i] !== prev_dout[i]) dbad[i]++;
      end
      prev_cs[i] = cs_v[i];
      prev_sclk[i] = sclk_v[i];
      prev_dout[i] = dout_v[i];
    end
  end

  function automatic logic [15:0] mk(input logic lead, input logic [7:0] d, input logic trail);
    return {{3{lead}}, d, {5{trail}}};
  endfunction

  task automatic set_start(input int i, input logic v);
    if (i == 0) start4 = v; else start1 = v;
  endtask

  task automatic run_frame(input int i, input logic [15:0] p, input logic [7:0] exp, input string name);
    int d;
    logic [7:0] e, got;
    if (i == 0) begin pat0 = p; post0 = 1'b1; q0.push_back(exp); end
    else        begin pat1 = p; post1 = 1'b1; q1.push_back(exp); end
    d = done_cnt[i];
    @(negedge clk); set_start(i, 1'b1);
    @(negedge clk); set_start(i, 1'b0);
    for (int c = 0; c < 1000 && done_cnt[i] == d; c++) @(negedge clk);
    #1;
    e = (i == 0) ? q0.pop_front() : q1.pop_front();
    checks++;
    if (done_cnt[i] == d) begin
      fails++; $display("FAIL %s timeout: no frame end seen", name);
    end else begin
      got = dout_v[i];
      if (got !== e) begin fails++; $display("FAIL %s dout: got %h expected %h", name, got, e); end
      checks++;
      if (falls[i] !== 16) begin fails++; $display("FAIL %s falls: got %0d expected 16", name, falls[i]); end
      checks++;
      if (rises[i] !== 16) begin fails++; $display("FAIL %s rises: got %0d expected 16", name, rises[i]); end
      checks++;
      if (frame_len[i] !== 33 * hd[i]) begin
        fails++; $display("FAIL %s cs_low: got %0d expected %0d", name, frame_len[i], 33 * hd[i]);
      end
      checks++;
      if (per_err[i] !== 0) begin fails++; $display("FAIL %s sclk_period: got %0d bad periods expected 0", name, per_err[i]); end
      checks++;
      if (dbad[i] !== 0) begin fails++; $display("FAIL %s dout_stable: got %0d changes expected 0", name, dbad[i]); end
    end
    repeat (2 * hd[i] + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cs_n4, sclk4, dout4} !== {1'b1, 1'b1, 8'h00}) begin
      fails++; $display("FAIL reset4: got cs=%b sclk=%b dout=%h expected 1 1 00", cs_n4, sclk4, dout4);
    end
    checks++;
    if ({cs_n1, sclk1, dout1} !== {1'b1, 1'b1, 8'h00}) begin
      fails++; $display("FAIL reset1: got cs=%b sclk=%b dout=%h expected 1 1 00", cs_n1, sclk1, dout1);
    end
    n_rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({cs_n4, sclk4, dout4, cs_n1, sclk1, dout1} !== {1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00}) begin
      fails++; $display("FAIL idle_hold: got cs4=%b sclk4=%b dout4=%h cs1=%b sclk1=%b dout1=%h expected 1 1 00",
                        cs_n4, sclk4, dout4, cs_n1, sclk1, dout1);
    end
  endtask

  task automatic test_single_frame();
    run_frame(0, mk(1'b0, 8'hAA, 1'b0), 8'hAA, "single_aa");
  endtask

  task automatic test_level_start();
    int s, d;
    logic [7:0] e;
    pat0 = mk(1'b0, 8'h96, 1'b0);
    q0.push_back(8'h96);
    s = starts[0]; d = done_cnt[0];
    @(negedge clk); start4 = 1'b1;
    for (int c = 0; c < 50 && cs_n4; c++) @(negedge clk);
    start4 = 1'b0;
    for (int c = 0; c < 1000 && done_cnt[0] == d; c++) @(negedge clk);
    #1;
    e = q0.pop_front();
    checks++;
    if (dout4 !== e) begin fails++; $display("FAIL level_dout: got %h expected %h", dout4, e); end
    repeat (300) @(negedge clk);
    checks++;
    if (starts[0] - s !== 1) begin fails++; $display("FAIL level_frames: got %0d expected 1", starts[0] - s); end
  endtask

  task automatic test_back_to_back();
    int s, d;
    logic [7:0] e;
    pat0 = mk(1'b0, 8'h5A, 1'b1);
    for (int k = 0; k < 3; k++) q0.push_back(8'h5A);
    s = starts[0]; d = done_cnt[0];
    @(negedge clk); start4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        for (int c = 0; c < 500 && starts[0] < s + 3; c++) @(negedge clk);
        start4 = 1'b0;
        #1;
        checks++;
        if (spacing[0] !== 35 * H0) begin fails++; $display("FAIL b2b_spacing: got %0d expected %0d", spacing[0], 35 * H0); end
        checks++;
        if (hi_len[0] !== 2 * H0) begin fails++; $display("FAIL b2b_cs_high: got %0d expected %0d", hi_len[0], 2 * H0); end
      end
      for (int c = 0; c < 1000 && done_cnt[0] < d + k + 1; c++) @(negedge clk);
      #1;
      e = q0.pop_front();
      checks++;
      if (done_cnt[0] < d + k + 1) begin
        fails++; $display("FAIL b2b_frame%0d timeout: no frame end seen", k);
      end else if (dout4 !== e) begin
        fails++; $display("FAIL b2b_frame%0d dout: got %h expected %h", k, dout4, e);
      end
    end
    start4 = 1'b0;
    repeat (300) @(negedge clk);
    checks++;
    if (starts[0] - s !== 3) begin fails++; $display("FAIL b2b_frames: got %0d expected 3", starts[0] - s); end
  endtask

  task automatic test_filler();
    run_frame(0, mk(1'b1, 8'h3C, 1'b1), 8'h3C, "filler_3c");
    run_frame(0, mk(1'b0, 8'h00, 1'b0), 8'h00, "data_00");
    run_frame(0, mk(1'b1, 8'hFF, 1'b1), 8'hFF, "data_ff");
    run_frame(0, mk(1'b1, 8'h00, 1'b1), 8'h00, "filler_00");
  endtask

  task automatic test_reset_mid();
    pat0 = mk(1'b0, 8'hC3, 1'b0);
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int c = 0; c < 200 && rises[0] < 6; c++) @(negedge clk);
    #2; n_rst = 1'b0;
    #1;
    checks++;
    if ({cs_n4, sclk4, dout4} !== {1'b1, 1'b1, 8'h00}) begin
      fails++; $display("FAIL mid_reset: got cs=%b sclk=%b dout=%h expected 1 1 00", cs_n4, sclk4, dout4);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(0, mk(1'b0, 8'hC3, 1'b1), 8'hC3, "after_reset");
  endtask

  task automatic test_div1();
    run_frame(1, mk(1'b0, 8'hAA, 1'b0), 8'hAA, "div1_aa");
    run_frame(1, mk(1'b1, 8'h71, 1'b1), 8'h71, "div1_71");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_level_start();
    test_back_to_back();
    test_filler();
    test_reset_mid();
    test_div1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
